// File: rtl/ahb_arbiter.sv
// ahb_arbiter: fixed-priority AHB bus arbiter (master 0 highest priority,
// master MASTER_NUMBER-1 is the default owner). Bursts and locked sequences
// freeze the grant so that ownership never changes mid-burst or mid-lock.
module ahb_arbiter #(
    parameter int unsigned MASTER_NUMBER = 4
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [MASTER_NUMBER-1:0] hbusreq,
    input  logic [MASTER_NUMBER-1:0] hlock,
    input  logic [1:0]               htrans,
    input  logic [2:0]               hburst,
    input  logic                     hready,
    output logic [MASTER_NUMBER-1:0] hgrant,
    output logic [3:0]               hmaster,
    output logic                     hmastlock
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BR_SINGLE = 3'd0,
        BR_INCR   = 3'd1,
        BR_WRAP4  = 3'd2,
        BR_INCR4  = 3'd3,
        BR_WRAP8  = 3'd4,
        BR_INCR8  = 3'd5,
        BR_WRAP16 = 3'd6,
        BR_INCR16 = 3'd7
    } hburst_e;

    localparam logic [MASTER_NUMBER-1:0] DEF_GRANT  = {1'b1, {(MASTER_NUMBER-1){1'b0}}};
    localparam logic [3:0]               DEF_MASTER = 4'(MASTER_NUMBER-1);

    logic [4:0]               r_beats;
    logic [MASTER_NUMBER-1:0] r_grant;
    logic [3:0]               r_master;
    logic                     r_mastlock;

    htrans_e                  w_trans;
    hburst_e                  w_burst;
    logic [4:0]               w_burst_len;
    logic [4:0]               w_beats_next;
    logic [3:0]               w_gidx;
    logic                     w_lock_own;
    logic                     w_frozen;
    logic [MASTER_NUMBER-1:0] w_arb_grant;
    logic                     w_found;

    assign w_trans = htrans_e'(htrans);
    assign w_burst = hburst_e'(hburst);

    // Remaining-address count loaded at the start of a fixed-length burst
    always_comb begin
        w_burst_len = 5'd0;
        case (w_burst)
            BR_WRAP4,  BR_INCR4:  w_burst_len = 5'd3;
            BR_WRAP8,  BR_INCR8:  w_burst_len = 5'd7;
            BR_WRAP16, BR_INCR16: w_burst_len = 5'd15;
            default:              w_burst_len = 5'd0;
        endcase
    end

    // Burst counter update for the current accepted transfer
    always_comb begin
        w_beats_next = r_beats;
        case (w_trans)
            TR_NONSEQ: w_beats_next = w_burst_len;
            TR_SEQ:    w_beats_next = (r_beats != 5'd0) ? r_beats - 5'd1 : r_beats;
            TR_BUSY:   w_beats_next = r_beats;
            default:   w_beats_next = 5'd0;
        endcase
    end

    // Binary index of the one-hot grant
    always_comb begin
        w_gidx = '0;
        for (int unsigned i = 0; i < MASTER_NUMBER; i++) begin
            if (r_grant[i]) w_gidx = 4'(i);
        end
    end

    // The grant is one-hot, so masking hlock with it selects the owner's lock bit
    assign w_lock_own = |(hlock & r_grant);
    assign w_frozen   = w_lock_own | (w_beats_next >= 5'd2);

    // Fixed priority: lowest-index request wins, default master when idle
    always_comb begin
        w_arb_grant = DEF_GRANT;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < MASTER_NUMBER; i++) begin
            if (hbusreq[i] && !w_found) begin
                w_arb_grant    = '0;
                w_arb_grant[i] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    // Arbiter state; everything holds while hready is low
    always_ff @(posedge hclk or negedge hreset) begin
        if (!hreset) begin
            r_beats    <= '0;
            r_grant    <= DEF_GRANT;
            r_master   <= DEF_MASTER;
            r_mastlock <= 1'b0;
        end else if (hready) begin
            r_beats    <= w_beats_next;
            if (!w_frozen) r_grant <= w_arb_grant;
            r_master   <= w_gidx;
            r_mastlock <= w_lock_own & (w_trans != TR_IDLE);
        end
    end

    assign hgrant    = r_grant;
    assign hmaster   = r_master;
    assign hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed tests for ahb_arbiter with hand-computed expectations.
module tb_ahb_arbiter;

    logic       hclk;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [3:0] hmaster;
    logic       hmastlock;

    int n_checks = 0;
    int n_errors = 0;

    ahb_arbiter #(.MASTER_NUMBER(4)) u_dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hreset  = 1'b1;
        hbusreq = 4'b0000;
        hlock   = 4'b0000;
        htrans  = 2'd0;
        hburst  = 3'd0;
        hready  = 1'b1;

        // Reset asserted mid-cycle takes effect without a clock edge
        #3 hreset = 1'b0;
        #1;
        check("rst_grant",    32'(hgrant),    32'h8);
        check("rst_master",   32'(hmaster),   32'd3);
        check("rst_mastlock", 32'(hmastlock), 32'd0);
        step();
        hreset = 1'b1;
        step();
        check("def_grant1",  32'(hgrant),  32'h8);
        check("def_master1", 32'(hmaster), 32'd3);
        step();
        check("def_grant2",  32'(hgrant),  32'h8);
        check("def_lock2",   32'(hmastlock), 32'd0);

        // Priority: masters 1 and 2 request, 1 wins
        hbusreq = 4'b0110;
        step();
        check("prio_grant_e1",  32'(hgrant),  32'h2);
        check("prio_master_e1", 32'(hmaster), 32'd3);
        step();
        check("prio_master_e2", 32'(hmaster), 32'd1);
        step();
        check("prio_grant_e3",  32'(hgrant),  32'h2);
        hbusreq = 4'b0100;
        step();
        check("hand_grant",   32'(hgrant),  32'h4);
        check("hand_master1", 32'(hmaster), 32'd1);
        step();
        check("hand_master2", 32'(hmaster), 32'd2);

        // INCR4 by master 2, master 0 requests at the NONSEQ edge
        hbusreq = 4'b0101;
        htrans  = 2'd2;
        hburst  = 3'd3;
        step();
        check("incr4_ns_grant", 32'(hgrant), 32'h4);
        htrans = 2'd3;
        step();
        check("incr4_s1_grant", 32'(hgrant), 32'h4);
        step();
        check("incr4_s2_grant",  32'(hgrant),  32'h1);
        check("incr4_s2_master", 32'(hmaster), 32'd2);
        step();
        check("incr4_s3_master", 32'(hmaster), 32'd0);
        check("incr4_s3_grant",  32'(hgrant),  32'h1);

        // Locked sequence by master 1
        htrans  = 2'd0;
        hburst  = 3'd0;
        hbusreq = 4'b0010;
        step();
        check("lk_pre_grant", 32'(hgrant), 32'h2);
        hlock  = 4'b0010;
        htrans = 2'd2;
        step();
        check("lk_grant0",    32'(hgrant),    32'h2);
        check("lk_mastlock0", 32'(hmastlock), 32'd1);
        check("lk_master0",   32'(hmaster),   32'd1);
        hbusreq = 4'b0011;
        step();
        check("lk_grant1",    32'(hgrant),    32'h2);
        check("lk_mastlock1", 32'(hmastlock), 32'd1);
        step();
        check("lk_grant2",    32'(hgrant),    32'h2);
        hlock = 4'b0000;
        step();
        check("lk_rel_grant",    32'(hgrant),    32'h1);
        check("lk_rel_mastlock", 32'(hmastlock), 32'd0);

        // hready stall with master 2 pending
        htrans  = 2'd0;
        hbusreq = 4'b0100;
        hready  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall%0d_grant", i),  32'(hgrant),    32'h1);
            check($sformatf("stall%0d_master", i), 32'(hmaster),   32'd1);
            check($sformatf("stall%0d_lock", i),   32'(hmastlock), 32'd0);
        end
        hready = 1'b1;
        step();
        check("stall_end_grant",  32'(hgrant),  32'h4);
        check("stall_end_master", 32'(hmaster), 32'd0);

        // Reset in the middle of an INCR8 by master 2
        htrans = 2'd2;
        hburst = 3'd5;
        step();
        check("i8_ns_master", 32'(hmaster), 32'd2);
        htrans = 2'd3;
        step();
        step();
        hreset = 1'b0;
        #2;
        check("mid_rst_grant",    32'(hgrant),    32'h8);
        check("mid_rst_master",   32'(hmaster),   32'd3);
        check("mid_rst_mastlock", 32'(hmastlock), 32'd0);
        hbusreq = 4'b0001;
        #2 hreset = 1'b1;
        step();
        check("post_rst_grant",  32'(hgrant),  32'h1);
        check("post_rst_master", 32'(hmaster), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
